// File: rtl/sram_like_mem.sv
// sram_like_mem: single-outstanding sram-like responder backed by a word-addressed RAM,
// answering each accepted request with data_ok exactly LATENCY cycles later.
module sram_like_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            be;
    logic                  unused_addr;

    // address bits above the word index alias onto the same RAM
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];
    assign idx         = addr_q[ADDR_WIDTH+1:2];
    assign be          = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                         size_q == 2'd1 && !addr_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                         size_q == 2'd2 && addr_q[1:0] == 2'b00 ? 4'b1111 : 4'b0000;
    assign addr_ok     = req && state_q == IDLE;
    assign data_ok     = state_q == RESP;
    assign rdata       = data_ok ? mem[idx] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = LATENCY > 1 ? WAIT : RESP;
                cnt_d   = 4'(LATENCY - 1);
                wr_d    = wr;
                size_d  = size;
                addr_d  = addr[ADDR_WIDTH+1:0];
                wdata_d = wdata;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // writes commit at the edge closing the response cycle, so reset in that cycle cancels them
    always_ff @(posedge clk) begin
        if (!rst && data_ok && wr_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_sram_like_mem.sv
// tb_sram_like_mem: scoreboarded directed test of sram_like_mem at LATENCY=2,
// plus latency/alias checks on LATENCY=1 and LATENCY=15 instances.
module tb_sram_like_mem;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rd;
        logic        chk;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        addr_ok, data_ok;

    logic        x_wr = 1'b0;
    logic [31:0] x_addr = '0;
    logic [31:0] x_wdata = '0;
    logic        x_req0 = 1'b0, x_req1 = 1'b0;
    logic        x_aok0, x_aok1, x_dok0, x_dok1;
    logic [31:0] x_rd0, x_rd1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    sram_like_mem #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );
    sram_like_mem #(.ADDR_WIDTH(12), .LATENCY(1)) d1 (
        .clk(clk), .rst(rst), .req(x_req0), .wr(x_wr), .size(2'd2), .addr(x_addr),
        .wdata(x_wdata), .rdata(x_rd0), .addr_ok(x_aok0), .data_ok(x_dok0)
    );
    sram_like_mem #(.ADDR_WIDTH(12), .LATENCY(15)) d15 (
        .clk(clk), .rst(rst), .req(x_req1), .wr(x_wr), .size(2'd2), .addr(x_addr),
        .wdata(x_wdata), .rdata(x_rd1), .addr_ok(x_aok1), .data_ok(x_dok1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops one expectation per data_ok and checks its cycle and read data
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_ok && data_ok) chk("addr_ok_with_data_ok", addr_ok, 1'b0);
            if (data_ok) begin
                if (sb.size() == 0) chk("data_ok_without_request", data_ok, 1'b0);
                else begin
                    mon_e = sb.pop_front();
                    chk("data_ok_cycle", cyc, mon_e.due);
                    if (mon_e.chk) chk("rdata", rdata, mon_e.rd);
                end
            end else chk("rdata_idle_zero", rdata, 32'h0);
        end
    end

    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, d,
                         input logic [31:0] e, input logic c, output int acc);
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", addr_ok, 1'b1);
        else sb.push_back('{e, c, acc + LAT});
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic lat_check(input int j, input int lat, input logic w, input logic [31:0] a, d, e,
                             input logic c);
        int t0 = -1;
        int t1 = -1;
        x_wr = w; x_addr = a; x_wdata = d;
        if (j == 0) x_req0 = 1'b1; else x_req1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (j == 0 ? x_aok0 : x_aok1) begin
                t0 = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        x_req0 = 1'b0; x_req1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (j == 0 ? x_dok0 : x_dok1) begin
                t1 = cyc;
                break;
            end
        end
        chk($sformatf("latency_%0d", lat), 32'(t1 - t0), 32'(lat));
        if (c) chk($sformatf("alias_rdata_lat%0d", lat), j == 0 ? x_rd0 : x_rd1, e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        chk("pending_responses", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, prev, c0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr_ok", addr_ok, 1'b0);
        chk("reset_data_ok", data_ok, 1'b0);
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(1, 2, 32'h40, 32'hDEADBEEF, 0, 0, a);
        issue(0, 2, 32'h40, 0, 32'hDEADBEEF, 1, a);
        issue(1, 2, 32'h40, 32'h11223344, 0, 0, a);
        issue(1, 0, 32'h41, 32'h0000AB00, 0, 0, a);
        issue(0, 2, 32'h40, 0, 32'h1122AB44, 1, a);
        issue(1, 1, 32'h42, 32'h55660000, 0, 0, a);
        issue(0, 2, 32'h40, 0, 32'h5566AB44, 1, a);
        issue(1, 2, 32'h41, 32'hFFFFFFFF, 0, 0, a);
        issue(0, 2, 32'h40, 0, 32'h5566AB44, 1, a);
        issue(1, 3, 32'h40, 32'h00000000, 0, 0, a);
        issue(0, 0, 32'h43, 0, 32'h5566AB44, 1, a);
        issue(0, 2, 32'h40 | (32'h1 << 14), 0, 32'h5566AB44, 1, a);
        issue(1, 2, 32'h44, 32'h01020304, 0, 0, a);
        prev = a;
        for (int i = 0; i < 6; i++) begin
            issue(0, 2, i % 2 ? 32'h44 : 32'h40, 0, i % 2 ? 32'h01020304 : 32'h5566AB44, 1, a);
            chk("accept_spacing", 32'(a - prev), 32'(LAT + 1));
            prev = a;
        end
        drain();
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'hCAFEF00D;
        for (int i = 0; i < 40 && !addr_ok; i++) @(negedge clk);
        chk("rst_test_accept", addr_ok, 1'b1);
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cyc;
        issue(0, 2, 32'h40, 0, 32'h5566AB44, 1, a);
        chk("accept_after_rst", a, c0);
        drain();
        lat_check(0, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0);
        lat_check(0, 1, 0, 32'h40 | (32'h1 << 14), 0, 32'hA5A5A5A5, 1);
        lat_check(1, 15, 1, 32'h40, 32'h3C3C5A5A, 0, 0);
        lat_check(1, 15, 0, 32'h40 | (32'h1 << 14), 0, 32'h3C3C5A5A, 1);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_like_mem.md
# sram_like_mem

Single-outstanding responder for the sram-like request interface (req/wr/size/addr/wdata in, rdata/addr_ok/data_ok out), the same handshake the cache presents on its memory-facing side. It backs that interface with an on-chip word-addressed RAM, answering after a fixed, parameterised latency. It serves as the downstream memory for cache and CPU bring-up and as the reference responder in cache testbenches.

## Interface
- ADDR_WIDTH, 12, word-index bits; memory holds 2^ADDR_WIDTH 32-bit words
- LATENCY, 2, cycles from accept to data_ok; legal range 1..15
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  request valid; held with its fields until addr_ok
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- addr  in  32  byte address
- wdata  in  32  write data, byte-lane aligned to addr[1:0]
- rdata  out  32  read word, valid only while data_ok = 1
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  response (read data or write completion) this cycle

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- addr_ok = req && state==IDLE (combinational). Accept = req && addr_ok at a rising edge: latch wr, size, addr, wdata; load counter with LATENCY-1; next state WAIT if LATENCY>1, else RESP.
- WAIT: counter decrements each cycle; at 1 → RESP on next edge.
- RESP: data_ok = 1 for exactly one cycle; next state IDLE unconditionally. addr_ok is 0 in WAIT and RESP; req is ignored there.
- Word index = latched addr[ADDR_WIDTH+1:2]; higher address bits ignored (aliasing).
- Byte enables from latched size/addr[1:0]: size 0 → one lane addr[1:0]; size 1 with addr[0]==0 → lanes {addr[1],0},{addr[1],1}; size 2 with addr[1:0]==0 → all four lanes; any other combination (misaligned or size 3) → no lanes.
- Write: enabled lanes of latched wdata written to RAM at the rising edge ending the RESP cycle; disabled lanes unchanged. Zero-lane writes still complete with data_ok.
- Read: rdata = full RAM word at word index during RESP, regardless of size; lane extraction is the requester's job. rdata = 0 whenever data_ok = 0.
- RAM contents are not cleared by reset; testbench preloads them with $readmemh.

## Timing
- Reset values: addr_ok 0, data_ok 0, rdata 0, state IDLE, counter 0, latched fields 0.
- Accept in cycle k → data_ok in cycle k+LATENCY. Earliest next accept is cycle k+LATENCY+1, so throughput is one access per LATENCY+1 cycles.
- addr_ok never coincides with data_ok.
- A write committed at the end of cycle k+LATENCY is visible to a read accepted in any later cycle.
- rst high in any cycle → next state IDLE, data_ok 0 next cycle. A RESP-cycle write is suppressed if rst is high in that cycle. An in-flight request is dropped with no response.
- req dropped before addr_ok: no effect. The requester may not retract after addr_ok.

## Test plan
- LATENCY=2, preload word 0x10 = 0xDEADBEEF; read addr 0x40 size 2 accepted in cycle 5 → data_ok only in cycle 7, rdata 0xDEADBEEF; rdata 0 in cycles 6 and 8.
- Byte write addr 0x41 size 0 wdata 0x0000AB00 over word 0x11223344, then word read 0x40 → 0x1122AB44. Halfword write addr 0x42 wdata 0x55660000 → 0x5566AB44.
- Misaligned write addr 0x41 size 2 wdata 0xFFFFFFFF → data_ok after LATENCY cycles, word unchanged on read-back.
- req held continuously with alternating addresses → addr_ok every LATENCY+1 cycles, never in the same cycle as data_ok; every request gets exactly one data_ok, in order.
- Write accepted, rst asserted in the WAIT cycle → no data_ok, RAM word unchanged, addr_ok available again the cycle after rst drops.
- LATENCY=1 and LATENCY=15 builds: data_ok exactly 1 and 15 cycles after accept; aliased addr 0x40 | (1<<14) (ADDR_WIDTH=12) reads the same word as 0x40.
